// File: rtl/vga_timing.sv
// vga_timing: raster timing generator (pixel tick, H/V phase FSMs, polarised syncs/blank, DE, line/frame pulses).
// Geometry is shadowed at run start and at each frame end; polarities are applied live.
module vga_timing #(
    parameter int VB_WIDTH = 16,
    parameter int TB_WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [7:0]          div_i,
    input  logic                hspol_i,
    input  logic                vspol_i,
    input  logic                blpol_i,
    input  logic [VB_WIDTH-1:0] hvlen_i,
    input  logic [VB_WIDTH-1:0] vvlen_i,
    input  logic [TB_WIDTH-1:0] hfp_i,
    input  logic [TB_WIDTH-1:0] hsn_i,
    input  logic [TB_WIDTH-1:0] hbp_i,
    input  logic [TB_WIDTH-1:0] vfp_i,
    input  logic [TB_WIDTH-1:0] vsn_i,
    input  logic [TB_WIDTH-1:0] vbp_i,
    output logic                pix_tick_o,
    output logic                hsync_o,
    output logic                vsync_o,
    output logic                blank_o,
    output logic                de_o,
    output logic [VB_WIDTH-1:0] pix_x_o,
    output logic [VB_WIDTH-1:0] pix_y_o,
    output logic                line_end_o,
    output logic                frame_end_o
);
    typedef enum logic [2:0] {IDLE, ACTIVE, FP, SYNC, BP} st_e;

    function automatic logic [VB_WIDTH-1:0] lim(st_e s, logic [VB_WIDTH-1:0] vis,
                                                logic [TB_WIDTH-1:0] fp, logic [TB_WIDTH-1:0] sn,
                                                logic [TB_WIDTH-1:0] bp);
        return s == ACTIVE ? vis : s == FP ? VB_WIDTH'(fp) : s == SYNC ? VB_WIDTH'(sn) : VB_WIDTH'(bp);
    endfunction

    function automatic st_e nxt(st_e s);
        return s == ACTIVE ? FP : s == FP ? SYNC : s == SYNC ? BP : ACTIVE;
    endfunction

    st_e                 h_st_q, h_st_d, v_st_q, v_st_d;
    logic [VB_WIDTH-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [7:0]          div_cnt_q, div_cnt_d, div_sh_q, div_sh_d;
    logic [VB_WIDTH-1:0] hvl_sh_q, hvl_sh_d, vvl_sh_q, vvl_sh_d;
    logic [TB_WIDTH-1:0] hfp_sh_q, hfp_sh_d, hsn_sh_q, hsn_sh_d, hbp_sh_q, hbp_sh_d;
    logic [TB_WIDTH-1:0] vfp_sh_q, vfp_sh_d, vsn_sh_q, vsn_sh_d, vbp_sh_q, vbp_sh_d;
    logic                run, tick, h_last, v_last, line_end, frame_end, load;
    logic                tick_d, le_d, fe_d, de_d;

    always_comb begin
        run       = h_st_q != IDLE;
        tick      = run && div_cnt_q == div_sh_q;
        h_last    = hcnt_q == lim(h_st_q, hvl_sh_q, hfp_sh_q, hsn_sh_q, hbp_sh_q);
        v_last    = vcnt_q == lim(v_st_q, vvl_sh_q, vfp_sh_q, vsn_sh_q, vbp_sh_q);
        line_end  = tick && h_st_q == BP && h_last;
        frame_end = line_end && v_st_q == BP && v_last;
        // The new frame starts on the reload edge, so it already sees the new geometry.
        load      = en_i && (!run || frame_end);
        div_sh_d  = load ? div_i   : div_sh_q;
        hvl_sh_d  = load ? hvlen_i : hvl_sh_q;
        vvl_sh_d  = load ? vvlen_i : vvl_sh_q;
        hfp_sh_d  = load ? hfp_i   : hfp_sh_q;
        hsn_sh_d  = load ? hsn_i   : hsn_sh_q;
        hbp_sh_d  = load ? hbp_i   : hbp_sh_q;
        vfp_sh_d  = load ? vfp_i   : vfp_sh_q;
        vsn_sh_d  = load ? vsn_i   : vsn_sh_q;
        vbp_sh_d  = load ? vbp_i   : vbp_sh_q;
        h_st_d    = !en_i ? IDLE : !run ? ACTIVE : (tick && h_last) ? nxt(h_st_q) : h_st_q;
        v_st_d    = !en_i ? IDLE : !run ? ACTIVE : (line_end && v_last) ? nxt(v_st_q) : v_st_q;
        hcnt_d    = (!en_i || !run || (tick && h_last)) ? '0 : tick ? hcnt_q + VB_WIDTH'(1) : hcnt_q;
        vcnt_d    = (!en_i || !run || (line_end && v_last)) ? '0 : line_end ? vcnt_q + VB_WIDTH'(1) : vcnt_q;
        div_cnt_d = (!en_i || !run || tick) ? 8'd0 : div_cnt_q + 8'd1;
        tick_d    = h_st_d != IDLE && div_cnt_d == div_sh_d;
        le_d      = tick_d && h_st_d == BP && hcnt_d == lim(h_st_d, hvl_sh_d, hfp_sh_d, hsn_sh_d, hbp_sh_d);
        fe_d      = le_d && v_st_d == BP && vcnt_d == lim(v_st_d, vvl_sh_d, vfp_sh_d, vsn_sh_d, vbp_sh_d);
        de_d      = h_st_d == ACTIVE && v_st_d == ACTIVE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_st_q      <= IDLE;
            v_st_q      <= IDLE;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            div_cnt_q   <= '0;
            div_sh_q    <= '0;
            hvl_sh_q    <= '0;
            vvl_sh_q    <= '0;
            hfp_sh_q    <= '0;
            hsn_sh_q    <= '0;
            hbp_sh_q    <= '0;
            vfp_sh_q    <= '0;
            vsn_sh_q    <= '0;
            vbp_sh_q    <= '0;
            pix_tick_o  <= 1'b0;
            hsync_o     <= 1'b0;
            vsync_o     <= 1'b0;
            blank_o     <= 1'b0;
            de_o        <= 1'b0;
            pix_x_o     <= '0;
            pix_y_o     <= '0;
            line_end_o  <= 1'b0;
            frame_end_o <= 1'b0;
        end else begin
            h_st_q      <= h_st_d;
            v_st_q      <= v_st_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            div_cnt_q   <= div_cnt_d;
            div_sh_q    <= div_sh_d;
            hvl_sh_q    <= hvl_sh_d;
            vvl_sh_q    <= vvl_sh_d;
            hfp_sh_q    <= hfp_sh_d;
            hsn_sh_q    <= hsn_sh_d;
            hbp_sh_q    <= hbp_sh_d;
            vfp_sh_q    <= vfp_sh_d;
            vsn_sh_q    <= vsn_sh_d;
            vbp_sh_q    <= vbp_sh_d;
            pix_tick_o  <= tick_d;
            hsync_o     <= (h_st_d == SYNC) ^ hspol_i;
            vsync_o     <= (v_st_d == SYNC) ^ vspol_i;
            blank_o     <= ~de_d ^ blpol_i;
            de_o        <= de_d;
            pix_x_o     <= h_st_d == ACTIVE ? hcnt_d : '0;
            pix_y_o     <= v_st_d == ACTIVE ? vcnt_d : '0;
            line_end_o  <= le_d;
            frame_end_o <= fe_d;
        end
    end
endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Raster timing generator directly downstream of the VGA APB4 config register block.
- Consumes the decoded CTRL/HVVL/HTIM/VTIM fields and produces:
  - pixel-rate tick;
  - horizontal/vertical counters;
  - polarised hsync/vsync/blank;
  - data-enable;
  - line-end and frame-end pulses for the pixel fetch and interrupt logic.

Parameters:
- VB_WIDTH, 16, width of visible-length fields (hvlen/vvlen) and pixel coordinates
- TB_WIDTH, 8, width of front-porch/sync/back-porch fields

Ports:
- clk_i  in  1  single clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- en_i  in  1  CTRL.EN; timing runs while 1
- div_i  in  8  CTRL.DIV; pixel tick period = div_i+1 clocks
- hspol_i  in  1  0: hsync active-high, 1: active-low
- vspol_i  in  1  same for vsync
- blpol_i  in  1  same for blank
- hvlen_i  in  VB_WIDTH  visible pixels per line minus 1
- vvlen_i  in  VB_WIDTH  visible lines per frame minus 1
- hfp_i, hsn_i, hbp_i  in  TB_WIDTH each  h front porch/sync/back porch length minus 1 (pixel ticks)
- vfp_i, vsn_i, vbp_i  in  TB_WIDTH each  v front porch/sync/back porch length minus 1 (lines)
- pix_tick_o  out  1  one-clock pulse per pixel period
- hsync_o  out  1  polarised horizontal sync
- vsync_o  out  1  polarised vertical sync
- blank_o  out  1  polarised blanking
- de_o  out  1  unpolarised: 1 when h and v both in ACTIVE
- pix_x_o  out  VB_WIDTH  pixel column in active region, 0 elsewhere
- pix_y_o  out  VB_WIDTH  line in active region, 0 elsewhere
- line_end_o  out  1  one-clock pulse on last tick of each line
- frame_end_o  out  1  one-clock pulse on last tick of each frame

Behaviour:
- Reset (rst_i=1): all outputs 0, all counters 0, both FSMs IDLE, shadow regs 0.
- Shadow regs:
  - Capture div/hvlen/vvlen/h*/v* on the IDLE->run transition and on every frame_end.
  - Mid-frame input changes take effect at the next frame start.
  - Polarity inputs are used live.
- Divider:
  - Counter 0..div_shadow.
  - pix_tick asserted on the clock where count==div_shadow, then count wraps to 0.
  - div=0: tick every clock.
- H FSM: IDLE -> ACTIVE -> FP -> SYNC -> BP -> ACTIVE.
  - Each phase lasts field+1 ticks; phase counter advances only on tick.
  - No zero-length phases exist.
  - Line = (hvlen+1)+(hfp+1)+(hsn+1)+(hbp+1) ticks.
- V FSM: same order (ACTIVE, FP, SYNC, BP).
  - Advances only on the tick that ends H BP; lengths counted in lines.
- IDLE->run:
  - Triggered when en_i is sampled 1 in IDLE.
  - On that edge, load shadows, set both FSMs to ACTIVE, zero all counters.
  - From the following cycle, de_o=1 and pix_x_o=pix_y_o=0.
- Outputs are registered and reflect current state:
  - hsync_o = (H==SYNC) ^ hspol_i
  - vsync_o = (V==SYNC) ^ vspol_i
  - de_o = (H==ACTIVE)&&(V==ACTIVE)
  - blank_o = ~de_o ^ blpol_i
  - pix_x_o increments on each tick in H ACTIVE; 0 outside it.
  - pix_y_o increments per line in V ACTIVE; 0 outside it.
- Pulses:
  - line_end_o coincides with pix_tick_o on the last tick of H BP.
  - frame_end_o is the same tick when V is also on the last line of V BP; line_end_o is also 1 then.
- Disable: en_i sampled 0 in any state -> next cycle IDLE.
  - Counters 0, pix_tick_o/de_o/pulses 0.
  - hsync_o=hspol_i, vsync_o=vspol_i, blank_o=~blpol_i (inactive/blanked levels).
  - Re-enable restarts from frame origin.
- IDLE steady outputs: same as disable levels.
- Simultaneous events:
  - rst_i beats en_i.
  - Frame-end shadow reload and the wrap to ACTIVE happen on the same edge; the new frame uses the new values.
- Counter widths never overflow: phase counters compare with ==, and field+1 fits by construction.

Test Plan:
- Reset/idle: rst_i=1 two cycles, then en_i=0, hspol=1, vspol=0, blpol=0 -> after reset all 0; then hsync_o=1, vsync_o=0, blank_o=1, de_o=0.
- Small raster: div=0, hvlen=3, hfp=0, hsn=1, hbp=0, vvlen=1, vfp=0, vsn=0, vbp=0, all pol=0, en=1.
  - Line = 8 clocks: de 4, hsync 2 at clocks 5-6.
  - Frame = 5 lines = 40 clocks; vsync high for line 3 only.
  - frame_end_o every 40 clocks; pix_x_o 0..3.
- Divider: same raster with div=2 -> pix_tick_o every 3 clocks; line 24 clocks, frame 120 clocks; de_o high 12 clocks per active line.
- Polarity: hspol=vspol=blpol=1 on small raster -> hsync_o/vsync_o low only during sync; blank_o high exactly when de_o=1.
- Shadowing: change hvlen 3->7 at clock 10 of frame -> current frame keeps 8-clock lines; next frame lines 12 clocks, starting right after frame_end_o.
- Disable mid-line: drop en_i during H SYNC -> next cycle IDLE levels and counters 0; re-enable -> de_o=1 next cycle with pix_x_o=0, pix_y_o=0.
